controle_diferenca_serial: RTL and testbench



---
 rtl/controle_diferenca_serial_if.sv | 25 ++
 rtl/controle_diferenca_serial.sv | 139 +++++++++++++
 tb/tb_controle_diferenca_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/controle_diferenca_serial_if.sv
// Request/result bundle between a requester and the bit-serial subtraction controller.
interface controle_diferenca_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
endinterface

// File: rtl/controle_diferenca_serial.sv
// Bit-serial A - B - bin: one full-difference cell reused LSB first, borrow kept in a flop.
module controle_diferenca_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    controle_diferenca_serial_if.slave    bus
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             cell_x_c, cell_y_c;
    logic             cell_diff_c, cell_brw_c;
    logic [WIDTH-1:0] assembled_c;

    // One-bit full-difference cell.
    assign cell_x_c    = a_q[0];
    assign cell_y_c    = b_q[0];
    assign cell_diff_c = cell_x_c ^ cell_y_c ^ brw_q;
    assign cell_brw_c  = (~cell_x_c & cell_y_c) | (~(cell_x_c ^ cell_y_c) & brw_q);
    assign assembled_c = {cell_diff_c, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            brw_q  <= brw_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                // Previous results stay visible until the new operation completes.
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = assembled_c;
                brw_d = cell_brw_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d  = assembled_c;
                    bout_d  = cell_brw_c;
                    ovf_d   = brw_q ^ cell_brw_c;
                    zero_d  = (assembled_c == '0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_controle_diferenca_serial.sv
// Bench for the bit-serial subtraction controller: arithmetic/timeline model plus directed literals.
module tb_controle_diferenca_serial;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    controle_diferenca_serial_if #(.WIDTH(WIDTH)) bus ();

    controle_diferenca_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: remaining busy cycles after an accepted request, results published on done.
    int         m_left = 0;
    logic [7:0] m_diff = '0, p_diff = '0;
    logic       m_bout = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic       p_bout = 1'b0, p_zero = 1'b0, p_ovf = 1'b0;

    always @(posedge clk) begin
        int ua, ub, sa, sb, sr, full;
        if (reset) begin
            m_left = 0;
            m_diff = '0; m_bout = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
        end else if (m_left == 0) begin
            if (bus.start === 1'b1) begin
                ua     = int'(bus.a);
                ub     = int'(bus.b);
                sa     = int'($signed(bus.a));
                sb     = int'($signed(bus.b));
                full   = ua - ub - int'(bus.bin);
                sr     = sa - sb - int'(bus.bin);
                p_diff = 8'(full);
                p_bout = (ua < ub + int'(bus.bin));
                p_zero = (p_diff == 8'h00);
                p_ovf  = (sr < -128) || (sr > 127);
                m_left = WIDTH + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_diff = p_diff; m_bout = p_bout; m_zero = p_zero; m_ovf = p_ovf;
            end
        end
    end

    bit chk_en = 1'b0;
    bit period_chk = 1'b0;
    bit have_last = 1'b0;
    int cyc = 0;
    int last_done = 0;
    int n_done = 0;

    // Cycle-by-cycle compare against the model, plus done-pulse bookkeeping.
    always @(negedge clk) begin
        cyc++;
        if (!period_chk) have_last = 1'b0;
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_left > 0));
            chk("done", 32'(bus.done), 32'(m_left == 1));
            chk("diff", 32'(bus.diff), 32'(m_diff));
            chk("bout", 32'(bus.bout), 32'(m_bout));
            chk("zero", 32'(bus.zero), 32'(m_zero));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
            if (bus.done === 1'b1) begin
                if (period_chk && have_last) chk("done_period", 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                have_last = 1'b1;
                n_done++;
            end
        end
    end

    // Issue one request from a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int bcnt);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        bcnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) bcnt++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    logic [7:0] t_a   [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h10};
    logic [7:0] t_b   [6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h10};
    logic       t_bin [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [7:0] t_d   [6] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80, 8'h00};
    logic       t_bo  [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       t_z   [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic       t_ov  [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    initial begin
        int lat, bcnt, d0, k;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases with literal results and timing.
        for (int i = 0; i < 6; i++) begin
            run_op(t_a[i], t_b[i], t_bin[i], lat, bcnt);
            chk("lat",       32'(lat),      32'd9);
            chk("busy_cnt",  32'(bcnt),     32'd9);
            chk("lit_diff",  32'(bus.diff), 32'(t_d[i]));
            chk("lit_bout",  32'(bus.bout), 32'(t_bo[i]));
            chk("lit_zero",  32'(bus.zero), 32'(t_z[i]));
            chk("lit_ovf",   32'(bus.ovf),  32'(t_ov[i]));
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // start in RUN (bit 3) and in DONE must be ignored.
        d0 = n_done;
        bus.a = 8'h05; bus.b = 8'h03; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.a = 8'hAA; bus.b = 8'h11; bus.bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("ign_done_seen", 32'(bus.done), 32'd1);
        chk("ign_diff", 32'(bus.diff), 32'h02);
        bus.a = 8'h44; bus.b = 8'h01; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ign_done_cnt", 32'(n_done - d0), 32'd1);
        chk("ign_diff_hold", 32'(bus.diff), 32'h02);

        // Reset in the middle of RUN abandons the operation.
        d0 = n_done;
        bus.a = 8'h80; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_diff", 32'(bus.diff), 32'd0);
        chk("mrst_bout", 32'(bus.bout), 32'd0);
        chk("mrst_zero", 32'(bus.zero), 32'd0);
        chk("mrst_ovf",  32'(bus.ovf),  32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("mrst_no_done", 32'(n_done - d0), 32'd0);
        run_op(8'h05, 8'h03, 1'b0, lat, bcnt);
        chk("post_rst_diff", 32'(bus.diff), 32'h02);
        chk("post_rst_lat",  32'(lat),      32'd9);
        @(negedge clk);

        // Start held high with random operands: back-to-back operations every 10 cycles.
        d0 = n_done;
        period_chk = 1'b1;
        bus.start = 1'b1;
        k = 0;
        while ((n_done - d0) < 1000 && k < 10100) begin
            bus.a   = 8'($urandom);
            bus.b   = 8'($urandom);
            bus.bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        period_chk = 1'b0;
        chk("stream_done_cnt", 32'(n_done - d0), 32'd1000);
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
